xalu_ise_issue: RTL and testbench

Core-side issuer for the custom-instruction ALU port. Accepts a decoded-but-unexecuted RV32 instruction word and its source operands from the pipeline. Classifies it as custom-0..3 and drives the ISE request bus (`ise_fn`/`ise_imm`/`ise_in1`/`ise_in2`/`ise_val`). Waits for `ise_oval`, then returns a registered write-back response, or an illegal-instruction flag, over a valid/ready handshake.

---
 rtl/xalu_ise_issue_if.sv | 32 +++
 rtl/xalu_ise_issue.sv | 91 +++++++++
 tb/tb_xalu_ise_issue.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/xalu_ise_issue_if.sv
// xalu_ise_issue_if: instruction, ISE request and write-back response bundle for the custom-ALU issuer.
interface xalu_ise_issue_if;
    logic        ins_val;
    logic        ins_rdy;
    logic [31:0] ins_word;
    logic [31:0] ins_rs1;
    logic [31:0] ins_rs2;
    logic        ise_val;
    logic [5:0]  ise_fn;
    logic [6:0]  ise_imm;
    logic [31:0] ise_in1;
    logic [31:0] ise_in2;
    logic        ise_oval;
    logic [31:0] ise_out;
    logic        rsp_val;
    logic        rsp_rdy;
    logic [4:0]  rsp_rd;
    logic [31:0] rsp_data;
    logic        rsp_ill;

    modport master (
        input  ins_val, ins_word, ins_rs1, ins_rs2, ise_oval, ise_out, rsp_rdy,
        output ins_rdy, ise_val, ise_fn, ise_imm, ise_in1, ise_in2,
               rsp_val, rsp_rd, rsp_data, rsp_ill
    );

    modport slave (
        output ins_val, ins_word, ins_rs1, ins_rs2, ise_oval, ise_out, rsp_rdy,
        input  ins_rdy, ise_val, ise_fn, ise_imm, ise_in1, ise_in2,
               rsp_val, rsp_rd, rsp_data, rsp_ill
    );
endinterface

// File: rtl/xalu_ise_issue.sv
// xalu_ise_issue: issues RV32 custom-0..3 instructions to the ISE port and returns a registered write-back.
// XALU_ISE_MULTICYCLE_EN enables waiting up to TIMEOUT extra cycles for ise_oval; otherwise EXEC is one cycle.
module xalu_ise_issue #(
    parameter int TIMEOUT = 15
) (
    input logic ise_clk,
    input logic ise_rst,
    xalu_ise_issue_if.master bus
);
`ifdef XALU_ISE_MULTICYCLE_EN
    localparam logic [3:0] BOUND = 4'(TIMEOUT);
`else
    localparam logic [3:0] BOUND = 4'(TIMEOUT) & 4'h0;
`endif

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic [6:0] opcode;
    logic       is_custom;
    logic       unused_bits;

    always_comb begin
        opcode      = bus.ins_word[6:0];
        is_custom   = opcode inside {7'h0B, 7'h2B, 7'h5B, 7'h7B};
        unused_bits = ^bus.ins_word[24:15];
    end

    always_ff @(posedge ise_clk or posedge ise_rst) begin
        if (ise_rst) begin
            state        <= IDLE;
            cnt          <= '0;
            bus.ins_rdy  <= 1'b1;
            bus.ise_val  <= 1'b0;
            bus.ise_fn   <= '0;
            bus.ise_imm  <= '0;
            bus.ise_in1  <= '0;
            bus.ise_in2  <= '0;
            bus.rsp_val  <= 1'b0;
            bus.rsp_rd   <= '0;
            bus.rsp_data <= '0;
            bus.rsp_ill  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.ins_val && bus.ins_rdy) begin
                    bus.ins_rdy <= 1'b0;
                    bus.rsp_rd  <= bus.ins_word[11:7];
                    cnt         <= '0;
                    if (is_custom) begin
                        bus.ise_fn  <= {1'b0, bus.ins_word[14:12], opcode[6:5]};
                        bus.ise_imm <= bus.ins_word[31:25];
                        bus.ise_in1 <= bus.ins_rs1;
                        bus.ise_in2 <= bus.ins_rs2;
                        bus.ise_val <= 1'b1;
                        state       <= EXEC;
                    end else begin
                        bus.rsp_val  <= 1'b1;
                        bus.rsp_ill  <= 1'b1;
                        bus.rsp_data <= '0;
                        state        <= RESP;
                    end
                end
                EXEC: begin
                    // A result arriving on the bound cycle still counts as valid
                    if (bus.ise_oval) begin
                        bus.ise_val  <= 1'b0;
                        bus.rsp_val  <= 1'b1;
                        bus.rsp_ill  <= 1'b0;
                        bus.rsp_data <= (bus.rsp_rd == 5'd0) ? 32'd0 : bus.ise_out;
                        state        <= RESP;
                    end else if (cnt == BOUND) begin
                        bus.ise_val  <= 1'b0;
                        bus.rsp_val  <= 1'b1;
                        bus.rsp_ill  <= 1'b1;
                        bus.rsp_data <= '0;
                        state        <= RESP;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                RESP: if (bus.rsp_rdy) begin
                    bus.rsp_val <= 1'b0;
                    bus.ins_rdy <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_xalu_ise_issue.sv
// tb_xalu_ise_issue: randomized and directed transactions checked against a transaction-level model.
module tb_xalu_ise_issue;
    localparam int TIMEOUT = 3;
`ifdef XALU_ISE_MULTICYCLE_EN
    localparam int BOUND = TIMEOUT;
`else
    localparam int BOUND = 0;
`endif
    localparam int NEVER = 99;

    logic ise_clk = 1'b0;
    logic ise_rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    xalu_ise_issue_if bus();

    xalu_ise_issue #(.TIMEOUT(TIMEOUT)) dut (
        .ise_clk (ise_clk),
        .ise_rst (ise_rst),
        .bus     (bus.master)
    );

    always #5 ise_clk = ~ise_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Custom slot index of an opcode, or -1 when it is not a custom opcode
    function automatic int custom_slot(input logic [6:0] op);
        logic [6:0] tbl [4] = '{7'b0001011, 7'b0101011, 7'b1011011, 7'b1111011};
        for (int i = 0; i < 4; i++) if (op == tbl[i]) return i;
        return -1;
    endfunction

    // d: EXEC cycle index (0-based) in which ise_oval is pulsed; k: cycles of response backpressure
    task automatic run_txn(input logic [31:0] word, input logic [31:0] rs1, input logic [31:0] rs2,
                           input int d, input logic [31:0] res, input int k);
        int slot, n_exec, lat, exp_exec, exp_lat;
        logic exp_ill, got;
        logic [31:0] exp_data;
        slot     = custom_slot(word[6:0]);
        exp_ill  = (slot < 0) || (d > BOUND);
        exp_data = (exp_ill || word[11:7] == 5'd0) ? 32'd0 : res;
        exp_exec = (slot < 0) ? 0 : ((d < BOUND ? d : BOUND) + 1);
        exp_lat  = exp_exec + 1;
        @(negedge ise_clk);
        check("ins_rdy_idle", 32'(bus.ins_rdy), 32'd1);
        bus.ins_val  = 1'b1;
        bus.ins_word = word;
        bus.ins_rs1  = rs1;
        bus.ins_rs2  = rs2;
        n_exec = 0;
        lat    = 0;
        got    = 1'b0;
        for (int c = 1; c < 40 && !got; c++) begin
            @(negedge ise_clk);
            bus.ins_val  = 1'b0;
            bus.ise_oval = 1'b0;
            if (bus.rsp_val) begin
                got = 1'b1;
                lat = c;
            end else begin
                check("ins_rdy_busy", 32'(bus.ins_rdy), 32'd0);
                if (bus.ise_val) begin
                    check("ise_fn", 32'(bus.ise_fn), 32'({1'b0, word[14:12], 2'(slot)}));
                    check("ise_imm", 32'(bus.ise_imm), 32'(word[31:25]));
                    check("ise_in1", bus.ise_in1, rs1);
                    check("ise_in2", bus.ise_in2, rs2);
                    bus.ise_oval = (n_exec == d);
                    bus.ise_out  = (n_exec == d) ? res : $urandom;
                    n_exec++;
                end
            end
        end
        bus.ise_oval = 1'b0;
        check("rsp_arrived", 32'(got), 32'd1);
        check("exec_cycles", 32'(n_exec), 32'(exp_exec));
        check("rsp_latency", 32'(lat), 32'(exp_lat));
        check("ise_val_in_resp", 32'(bus.ise_val), 32'd0);
        for (int s = 0; s <= k; s++) begin
            if (s > 0) @(negedge ise_clk);
            check("rsp_val_hold", 32'(bus.rsp_val), 32'd1);
            check("rsp_rd", 32'(bus.rsp_rd), 32'(word[11:7]));
            check("rsp_data", bus.rsp_data, exp_data);
            check("rsp_ill", 32'(bus.rsp_ill), 32'(exp_ill));
            check("ins_rdy_resp", 32'(bus.ins_rdy), 32'd0);
        end
        bus.rsp_rdy = 1'b1;
        @(negedge ise_clk);
        bus.rsp_rdy = 1'b0;
        check("rsp_val_drop", 32'(bus.rsp_val), 32'd0);
        check("ins_rdy_after", 32'(bus.ins_rdy), 32'd1);
    endtask

    initial begin
        logic [31:0] w;
        bus.ins_val  = 1'b0;
        bus.ins_word = '0;
        bus.ins_rs1  = '0;
        bus.ins_rs2  = '0;
        bus.ise_oval = 1'b0;
        bus.ise_out  = '0;
        bus.rsp_rdy  = 1'b0;
        repeat (3) @(negedge ise_clk);
        ise_rst = 1'b0;
        check("rst_ins_rdy", 32'(bus.ins_rdy), 32'd1);
        check("rst_ise_val", 32'(bus.ise_val), 32'd0);
        check("rst_rsp_val", 32'(bus.rsp_val), 32'd0);
        check("rst_rsp_ill", 32'(bus.rsp_ill), 32'd0);
        check("rst_ise_fn", 32'(bus.ise_fn), 32'd0);
        check("rst_ise_imm", 32'(bus.ise_imm), 32'd0);
        check("rst_ise_in1", bus.ise_in1, 32'd0);
        check("rst_ise_in2", bus.ise_in2, 32'd0);
        check("rst_rsp_rd", 32'(bus.rsp_rd), 32'd0);
        check("rst_rsp_data", bus.rsp_data, 32'd0);

        run_txn(32'h0020_80AB, 32'h1234_5678, 32'h9ABC_DEF0, 0, 32'hDEAD_BEEF, 0);
        run_txn(32'h0000_0033, 32'h1111_1111, 32'h2222_2222, 0, 32'h5555_5555, 0);
        run_txn(32'hFE00_F5FB, 32'hA5A5_A5A5, 32'h5A5A_5A5A, NEVER, 32'h0BAD_F00D, 1);
        run_txn(32'h4A00_3D5B, 32'h0000_0001, 32'h0000_0002, BOUND, 32'hCAFE_F00D, 0);
        run_txn(32'h0020_802B, 32'h0000_0003, 32'h0000_0004, 0, 32'hFFFF_FFFF, 0);
        run_txn(32'h0000_600B, 32'h0000_0005, 32'h0000_0006, NEVER, 32'hFFFF_FFFF, 0);
        run_txn(32'h1C00_1F8B, 32'h7777_0000, 32'h0000_7777, 0, 32'h1357_9BDF, 5);

        // Abort mid-EXEC: outputs clear at once and the instruction never responds
        @(negedge ise_clk);
        bus.ins_val  = 1'b1;
        bus.ins_word = 32'h0000_10FB;
        @(negedge ise_clk);
        bus.ins_val = 1'b0;
        check("abort_in_exec", 32'(bus.ise_val), 32'd1);
        #1 ise_rst = 1'b1;
        #1;
        check("abort_ise_val", 32'(bus.ise_val), 32'd0);
        check("abort_rsp_val", 32'(bus.rsp_val), 32'd0);
        check("abort_ins_rdy", 32'(bus.ins_rdy), 32'd1);
        @(negedge ise_clk);
        ise_rst = 1'b0;
        bus.ise_oval = 1'b1;
        bus.ise_out  = 32'hBAD0_BAD0;
        for (int c = 0; c < 6; c++) begin
            @(negedge ise_clk);
            check("abort_no_rsp", 32'(bus.rsp_val), 32'd0);
            check("abort_no_req", 32'(bus.ise_val), 32'd0);
        end
        bus.ise_oval = 1'b0;

        for (int i = 0; i < 150; i++) begin
            w = $urandom;
            if ($urandom_range(0, 3) != 0) w[6:0] = {2'($urandom_range(0, 3)), 5'b11011};
            if ($urandom_range(0, 5) == 0) w[11:7] = 5'd0;
            run_txn(w, $urandom, $urandom,
                    ($urandom_range(0, 4) == 0) ? NEVER : int'($urandom_range(0, BOUND + 2)),
                    $urandom, int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
